conf_mul_sched: RTL and testbench
=================================

CONF_MUL_SCHED -- requirements
Module: conf_mul_sched

Interface
REQ-001 Parameter DATA_PATH_BITWIDTH, default 24: operand width; result width is DATA_PATH_BITWIDTH-2.
REQ-002 Parameter OP_BITWIDTH, default 16: passed through for configuration consistency; no internal effect.
REQ-003 Parameter MUL_LATENCY, default 2, legal range 1..15: cycles from first EXEC cycle to mul_d valid.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 Port list, one per line (name, direction, width, meaning):
  clk  in  1  rising-edge clock
  rst  in  1  synchronous, active-low reset
  req0_valid  in  1  requester 0 has an operation
  req0_ready  out  1  requester 0 operation accepted this cycle
  req0_a, req0_b  in  DATA_PATH_BITWIDTH  requester 0 operands
  req0_apx  in  1  1 = approximate mode, 0 = accurate mode
  req1_valid, req1_ready, req1_a, req1_b, req1_apx  (same as requester 0, for requester 1)
  rsp0_valid  out  1  result for requester 0 available
  rsp0_ready  in  1  requester 0 takes result
  rsp1_valid, rsp1_ready  (same, requester 1)
  rsp_d  out  DATA_PATH_BITWIDTH-2  result, qualified by rsp0_valid/rsp1_valid
  mul_a, mul_b  out  DATA_PATH_BITWIDTH  operands to shared multiplier
  mul_racc, mul_rapx  out  1 each  multiplier mode select, always one-hot
  mul_d  in  DATA_PATH_BITWIDTH-2  multiplier result
  busy  out  1  high in any state other than IDLE

Function
REQ-006 The FSM SHALL have four states: IDLE, CFG, EXEC, DONE.
REQ-007 reqN_ready SHALL be combinational: high only in IDLE and only for the granted requester.
REQ-008 Grant in IDLE:
  - one valid requester: that requester is granted
  - both valid: the requester selected by round-robin pointer rr is granted
REQ-009 On accept (reqN_valid and reqN_ready):
  - capture a, b and apx into mul_a, mul_b and the pending mode
  - record the granted requester
  - go to CFG if the pending mode differs from the current mode, else go to EXEC
REQ-010 CFG SHALL last exactly one cycle, then go to EXEC.
  - mul_racc/mul_rapx update on the CFG->EXEC edge
  - the multiplier therefore sees the new mode for the whole of EXEC
REQ-011 EXEC counter:
  - loaded with MUL_LATENCY-1 on entry
  - decremented each EXEC cycle
  - when it reads 0: mul_d captured into rsp_d, next state DONE
  - EXEC lasts exactly MUL_LATENCY cycles
REQ-012 mul_a, mul_b, mul_racc and mul_rapx SHALL remain stable from accept until DONE exits.
REQ-013 DONE:
  - rspN_valid is high for the recorded requester only
  - on rspN_ready: go to IDLE and set rr to the other requester
  - otherwise hold state and rsp_d
REQ-014 Latency from accept cycle T: rspN_valid asserts at T+MUL_LATENCY+1 with no mode change, or T+MUL_LATENCY+2 with a mode change.
REQ-015 reqN_valid, operand or mode changes while busy SHALL have no effect; no request is queued.
REQ-016 mul_racc and mul_rapx SHALL never both be high or both be low.
REQ-017 An unserved valid requester SHALL be granted no later than the next IDLE cycle after the other requester's response completes.

Reset
REQ-018 When rst=0 at a rising edge, the block SHALL enter IDLE and set:
  - rr=0
  - mul_a=0, mul_b=0, rsp_d=0
  - mul_racc=1, mul_rapx=0
  - busy=0, rsp0_valid=0, rsp1_valid=0
  - req0_ready/req1_ready follow REQ-007 from the cycle after reset
REQ-019 Reset asserted in CFG, EXEC or DONE SHALL abort the operation silently: no rspN_valid, and the mode returns to accurate.

Verification
REQ-020 Single accurate op, MUL_LATENCY=2: req0 a=3 b=5 apx=0 accepted at T, mul_d=15 -> rsp0_valid at T+3, rsp_d=15, mul_racc=1 throughout.
REQ-021 Mode switch: req1 apx=1 accepted at T after reset -> CFG at T+1, mul_rapx=1 from T+2, rsp1_valid at T+4.
REQ-022 Contention: req0 and req1 both valid from reset, rsp_ready tied high -> grants alternate 0,1,0,1, with no requester granted twice in a row while the other waits.
REQ-023 Backpressure: rsp0_ready held low 5 cycles in DONE -> rsp0_valid and rsp_d stable, req1_ready=0 throughout; completes on the first cycle rsp0_ready=1.
REQ-024 Reset mid-EXEC: rst=0 in the second EXEC cycle -> next cycle IDLE, busy=0, no rsp valid, mul_racc=1, mul_a=0.
REQ-025 Assertions on every cycle:
  - mul_racc XOR mul_rapx = 1
  - at most one reqN_ready high
  - at most one rspN_valid high
  - mul_a/mul_b stable while busy

Source files
------------

// File: rtl/conf_mul_sched.sv
// Arbitrates two requesters onto one shared multiplier, with a CFG cycle whenever the mode changes.
// Accept to response is MUL_LATENCY+1 cycles, or +2 when the mode changes; DONE holds until rspN_ready, and nothing is accepted while busy.
module conf_mul_sched #(
  parameter int DATA_PATH_BITWIDTH = 24,
  parameter int OP_BITWIDTH        = 16,
  parameter int MUL_LATENCY        = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req0_valid,
  output logic                          req0_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] req0_a,
  input  logic [DATA_PATH_BITWIDTH-1:0] req0_b,
  input  logic                          req0_apx,
  input  logic                          req1_valid,
  output logic                          req1_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] req1_a,
  input  logic [DATA_PATH_BITWIDTH-1:0] req1_b,
  input  logic                          req1_apx,
  output logic                          rsp0_valid,
  input  logic                          rsp0_ready,
  output logic                          rsp1_valid,
  input  logic                          rsp1_ready,
  output logic [DATA_PATH_BITWIDTH-3:0] rsp_d,
  output logic [DATA_PATH_BITWIDTH-1:0] mul_a,
  output logic [DATA_PATH_BITWIDTH-1:0] mul_b,
  output logic                          mul_racc,
  output logic                          mul_rapx,
  input  logic [DATA_PATH_BITWIDTH-3:0] mul_d,
  output logic                          busy
);

  localparam int RW = DATA_PATH_BITWIDTH - 2;
  localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 1);

  if (MUL_LATENCY < 1 || MUL_LATENCY > 15 || OP_BITWIDTH < 1 || DATA_PATH_BITWIDTH < 3) begin : g_bad_param
    $error("conf_mul_sched: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, CFG, EXEC, DONE} state_t;

  state_t                        state_q, state_d;
  logic                          rr_q, rr_d;
  logic                          gnt_q, gnt_d;
  logic                          apx_q, apx_d;
  logic                          mode_q, mode_d;
  logic [3:0]                    cnt_q, cnt_d;
  logic [DATA_PATH_BITWIDTH-1:0] mul_a_q, mul_a_d;
  logic [DATA_PATH_BITWIDTH-1:0] mul_b_q, mul_b_d;
  logic [RW-1:0]                 rsp_d_q, rsp_d_d;
  logic                          sel;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    apx_d      = apx_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    rsp_d_d    = rsp_d_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    // Round-robin only breaks ties; a lone requester always wins.
    sel = (req0_valid && req1_valid) ? rr_q : req1_valid;

    unique case (state_q)
      IDLE: begin
        req0_ready = req0_valid && !sel;
        req1_ready = req1_valid && sel;
        if (req0_ready || req1_ready) begin
          gnt_d   = sel;
          mul_a_d = sel ? req1_a : req0_a;
          mul_b_d = sel ? req1_b : req0_b;
          apx_d   = sel ? req1_apx : req0_apx;
          cnt_d   = CNT_INIT;
          state_d = (apx_d != mode_q) ? CFG : EXEC;
        end
      end
      CFG: begin
        mode_d  = apx_q;
        cnt_d   = CNT_INIT;
        state_d = EXEC;
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          rsp_d_d = mul_d;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        rsp0_valid = !gnt_q;
        rsp1_valid = gnt_q;
        if (gnt_q ? rsp1_ready : rsp0_ready) begin
          rr_d    = !gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      gnt_q   <= 1'b0;
      apx_q   <= 1'b0;
      mode_q  <= 1'b0;
      cnt_q   <= 4'd0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      rsp_d_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      apx_q   <= apx_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      rsp_d_q <= rsp_d_d;
    end
  end

  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign mul_rapx = mode_q;
  assign mul_racc = !mode_q;
  assign rsp_d    = rsp_d_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_conf_mul_sched.sv
// Directed scoreboard bench for conf_mul_sched: stimulus pushes expected results, a negedge monitor pops on each response handshake.
module tb_conf_mul_sched;
  localparam int DW  = 24;
  localparam int RW  = DW - 2;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req0_apx;
  logic          req1_valid, req1_ready, req1_apx;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [RW-1:0] rsp_d;
  logic [DW-1:0] mul_a, mul_b;
  logic          mul_racc, mul_rapx;
  logic [RW-1:0] mul_d;
  logic          busy;

  typedef struct packed {
    logic          id;
    logic [RW-1:0] d;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            t_acc = 0;
  bit            mon_en = 1'b0;
  bit            prev_busy = 1'b0;
  logic [DW-1:0] prev_a, prev_b;
  logic [2*DW-1:0] prod;

  conf_mul_sched #(
    .DATA_PATH_BITWIDTH(DW),
    .OP_BITWIDTH(16),
    .MUL_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_apx(req0_apx),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_apx(req1_apx),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_d(rsp_d), .mul_a(mul_a), .mul_b(mul_b), .mul_racc(mul_racc), .mul_rapx(mul_rapx),
    .mul_d(mul_d), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stub: approximate mode drops the low 4 product bits.
  always_comb begin
    prod  = mul_a * mul_b;
    mul_d = mul_rapx ? (prod[RW-1:0] & ~RW'(15)) : prod[RW-1:0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mode_onehot", 32'(mul_racc ^ mul_rapx), 32'd1);
      chk("req_ready_excl", 32'(req0_ready & req1_ready), 32'd0);
      chk("rsp_valid_excl", 32'(rsp0_valid & rsp1_valid), 32'd0);
      if (prev_busy && busy) begin
        chk("mul_a_stable", 32'(mul_a), 32'(prev_a));
        chk("mul_b_stable", 32'(mul_b), 32'(prev_b));
      end
      prev_busy = busy;
      prev_a    = mul_a;
      prev_b    = mul_b;
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected actual=rsp0:%0b/rsp1:%0b required=none", rsp0_valid, rsp1_valid);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 32'(rsp1_valid), 32'(e.id));
          chk("rsp_d", 32'(rsp_d), 32'(e.d));
        end
      end
    end
  end

  task automatic issue(input bit id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input bit apx, input logic [RW-1:0] exp_d, input bit push);
    bit ok;
    @(posedge clk); #1;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_apx = apx;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_apx = apx;
    end
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = id ? req1_ready : req0_ready;
    end
    chk("req_ready_seen", 32'(ok), 32'd1);
    t_acc = cyc;
    if (ok && push) exp_q.push_back(exp_t'{id, exp_d});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input bit id, input int lat);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = id ? rsp1_valid : rsp0_valid;
    end
    chk("rsp_valid_seen", 32'(ok), 32'd1);
    chk("rsp_latency", 32'(cyc - t_acc), 32'(lat));
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = !busy;
    end
    chk("idle_seen", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_apx = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_apx = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_racc", 32'(mul_racc), 32'd1);
    chk("rst_rapx", 32'(mul_rapx), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    chk("rst_rsp_d", 32'(rsp_d), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single accurate op, no mode change.
    issue(1'b0, 24'd3, 24'd5, 1'b0, 22'd15, 1'b1);
    wait_rsp(1'b0, LAT + 1);
    chk("A_racc", 32'(mul_racc), 32'd1);

    // Mode switch to approximate straight after reset: 63 -> 48.
    do_reset();
    issue(1'b1, 24'd7, 24'd9, 1'b1, 22'd48, 1'b1);
    @(negedge clk);
    chk("B_cfg_busy", 32'(busy), 32'd1);
    chk("B_cfg_rapx", 32'(mul_rapx), 32'd0);
    @(negedge clk);
    chk("B_exec_rapx", 32'(mul_rapx), 32'd1);
    wait_rsp(1'b1, LAT + 2);

    // Back to accurate (switch), then accurate again (no switch).
    issue(1'b0, 24'd2, 24'd4, 1'b0, 22'd8, 1'b1);
    wait_rsp(1'b0, LAT + 2);
    issue(1'b1, 24'd5, 24'd6, 1'b0, 22'd30, 1'b1);
    wait_rsp(1'b1, LAT + 1);

    // Contention: both held valid, grants must alternate starting with 0.
    do_reset();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 24'd10; req0_b = 24'd10; req0_apx = 1'b0;
    req1_valid = 1'b1; req1_a = 24'd3;  req1_b = 24'd4;  req1_apx = 1'b0;
    for (int g = 0; g < 4; g++) begin
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge clk);
        ok = req0_ready || req1_ready;
      end
      chk("E_grant_seen", 32'(ok), 32'd1);
      chk("E_grant_id", 32'(req1_ready), 32'(g % 2));
      if (ok) exp_q.push_back(exp_t'{req1_ready, req1_ready ? 22'd12 : 22'd100});
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();

    // Backpressure: rsp0_ready low for 5 DONE cycles while req1 waits.
    rsp0_ready = 1'b0;
    issue(1'b0, 24'd6, 24'd7, 1'b0, 22'd42, 1'b1);
    req1_valid = 1'b1; req1_a = 24'd1; req1_b = 24'd1; req1_apx = 1'b0;
    wait_rsp(1'b0, LAT + 1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("F_hold_valid", 32'(rsp0_valid), 32'd1);
      chk("F_hold_rsp_d", 32'(rsp_d), 32'd42);
      chk("F_req1_ready", 32'(req1_ready), 32'd0);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("F_release_valid", 32'(rsp0_valid), 32'd1);
    @(negedge clk);
    chk("F_done_busy", 32'(busy), 32'd0);

    // Reset in the second EXEC cycle of an approximate op.
    issue(1'b1, 24'd3, 24'd3, 1'b1, 22'd0, 1'b1);
    wait_rsp(1'b1, LAT + 2);
    issue(1'b0, 24'd11, 24'd13, 1'b1, 22'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("G_busy", 32'(busy), 32'd0);
    chk("G_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("G_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("G_racc", 32'(mul_racc), 32'd1);
    chk("G_mul_a", 32'(mul_a), 32'd0);
    repeat (6) @(negedge clk);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
